read_logic_gen: RTL and testbench

READ_LOGIC_GEN -- requirements
Module: read_logic_gen

---
 rtl/read_logic_gen.sv | 157 +++++++++++++++
 tb/tb_read_logic_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/read_logic_gen.sv
// Tiled BRAM read sequencer: issues NUM_READS_PER_TILE strided reads per tile
// over NUM_TILES tiles and tracks data return through a latency shift register.
module read_logic_gen #(
    parameter int NUM_READS_PER_TILE = 16,
    parameter int ADDR_WIDTH         = 16,
    parameter int ADDR_STRIDE        = 24,
    parameter int NUM_TILES          = 24,
    parameter int READ_LATENCY       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_read,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  stall,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic                  data_valid,
    output logic                  tile_last,
    output logic                  busy,
    output logic                  read_done
);

    localparam int OFF_W  = (NUM_READS_PER_TILE > 1) ? $clog2(NUM_READS_PER_TILE) : 1;
    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int CNT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [OFF_W-1:0]      OFF_LAST  = OFF_W'(NUM_READS_PER_TILE - 1);
    localparam logic [TILE_W-1:0]     TILE_LAST = TILE_W'(NUM_TILES - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        READING,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [OFF_W-1:0]        offset_q, offset_d;
    logic [TILE_W-1:0]       tile_q, tile_d;
    logic [ADDR_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] lst_q, lst_d;

    logic issue;
    logic last_off;

    // acc_q tracks offset*ADDR_STRIDE incrementally, avoiding a multiplier
    assign issue      = (state_q == READING) && !stall;
    assign last_off   = (offset_q == OFF_LAST);
    assign bram_en    = issue;
    assign bram_addr  = (state_q == READING)
                      ? base_q + ADDR_WIDTH'(tile_q) + acc_q
                      : base_q;
    assign data_valid = vld_q[READ_LATENCY-1];
    assign tile_last  = lst_q[READ_LATENCY-1];
    assign busy       = (state_q != IDLE);
    assign read_done  = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        offset_d = offset_q;
        tile_d   = tile_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        lst_d    = lst_q;

        vld_d[0] = issue;
        lst_d[0] = issue && last_off;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end

        unique case (state_q)
            IDLE: begin
                if (start_read) begin
                    base_d   = base_addr;
                    offset_d = '0;
                    tile_d   = '0;
                    acc_d    = '0;
                    state_d  = READING;
                end
            end
            READING: begin
                if (issue) begin
                    if (last_off) begin
                        offset_d = '0;
                        acc_d    = '0;
                        if (tile_q == TILE_LAST) begin
                            tile_d  = '0;
                            cnt_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            tile_d = tile_q + TILE_W'(1);
                        end
                    end else begin
                        offset_d = offset_q + OFF_W'(1);
                        acc_d    = acc_q + STRIDE;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d  = IDLE;
            offset_d = '0;
            tile_d   = '0;
            acc_d    = '0;
            cnt_d    = '0;
            vld_d    = '0;
            lst_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            offset_q <= '0;
            tile_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            lst_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            tile_q   <= tile_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
        end
    end

endmodule

// File: tb/tb_read_logic_gen.sv
// Randomized bench for read_logic_gen against a per-read arithmetic model
// of the tiled address sequence and its timing.
module tb_read_logic_gen;

    localparam int AW   = 16;
    localparam int NR   = 16;
    localparam int NT   = 24;
    localparam int STR  = 24;
    localparam int LAT  = 2;
    localparam int NTOT = NR * NT;
    localparam int MAXC = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_read = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          data_valid;
    logic          tile_last;
    logic          busy;
    logic          read_done;

    int n_checks = 0;
    int n_errors = 0;

    read_logic_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_read (start_read),
        .base_addr  (base_addr),
        .stall      (stall),
        .abort      (abort),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .data_valid (data_valid),
        .tile_last  (tile_last),
        .busy       (busy),
        .read_done  (read_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base,
                                                 input int k);
        logic [31:0] a;
        a = 32'(base) + 32'(k / NR) + 32'((k % NR) * STR);
        return a[AW-1:0];
    endfunction

    // One clock cycle: drive inputs just after the rising edge, sample at falling edge
    task automatic step(input logic st, input logic [AW-1:0] ba,
                        input logic sl, input logic ab);
        @(posedge clk);
        #1;
        start_read = st;
        base_addr  = ba;
        stall      = sl;
        abort      = ab;
        @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bram_en, data_valid, tile_last, busy, read_done, bram_addr});
    endfunction

    // mode 0: no stall, 1: stall in cycles 5-7, 2: random stall
    task automatic run_pass(input logic [AW-1:0] base, input int mode,
                            input bit extra_start);
        logic          s_at [MAXC];
        logic          e_en [MAXC];
        logic          e_dv [MAXC];
        logic          e_tl [MAXC];
        logic          e_bz [MAXC];
        logic          e_dn [MAXC];
        logic          e_ac [MAXC];
        logic [AW-1:0] e_ad [MAXC];
        int k, c, done_c, done_at;
        int m_en, m_ad, m_dv, m_tl, m_bz, m_dn;
        int nrd, ndv, ntl, ndn;
        for (int i = 0; i < MAXC; i++) begin
            s_at[i] = 1'b0; e_en[i] = 1'b0; e_dv[i] = 1'b0;
            e_tl[i] = 1'b0; e_bz[i] = 1'b0; e_dn[i] = 1'b0;
            e_ac[i] = 1'b0; e_ad[i] = '0;
        end
        for (int i = 1; i < MAXC; i++) begin
            if (mode == 1) s_at[i] = (i >= 5 && i <= 7);
            else if (mode == 2) s_at[i] = ($urandom_range(0, 3) == 0);
        end
        k = 0;
        c = 1;
        while (k < NTOT) begin
            e_bz[c] = 1'b1;
            e_ac[c] = 1'b1;
            e_ad[c] = model_addr(base, k);
            if (!s_at[c]) begin
                e_en[c]       = 1'b1;
                e_dv[c + LAT] = 1'b1;
                e_tl[c + LAT] = ((k % NR) == NR - 1);
                k++;
            end
            c++;
        end
        for (int i = 0; i <= LAT; i++) e_bz[c + i] = 1'b1;
        done_c       = c + LAT;
        e_dn[done_c] = 1'b1;

        m_en = 0; m_ad = 0; m_dv = 0; m_tl = 0; m_bz = 0; m_dn = 0;
        nrd = 0; ndv = 0; ntl = 0; ndn = 0; done_at = -1;
        for (int i = 0; i <= done_c + 3; i++) begin
            if (extra_start && i == 50) step(1'b1, base ^ 16'h1234, s_at[i], 1'b0);
            else step(i == 0, base, s_at[i], 1'b0);
            if (bram_en !== e_en[i]) m_en++;
            if (e_ac[i] && bram_addr !== e_ad[i]) m_ad++;
            if (data_valid !== e_dv[i]) m_dv++;
            if (tile_last !== e_tl[i]) m_tl++;
            if (busy !== e_bz[i]) m_bz++;
            if (read_done !== e_dn[i]) m_dn++;
            nrd += int'(bram_en === 1'b1);
            ndv += int'(data_valid === 1'b1);
            ntl += int'(tile_last === 1'b1);
            if (read_done === 1'b1) begin
                ndn++;
                done_at = i;
            end
            if (mode == 1 && i == 6) chk("stall_hold_addr", 64'(bram_addr), 64'd96);
            if (base == 16'hFFF0 && i == 2) chk("wrap_addr", 64'(bram_addr), 64'h8);
        end
        chk("en_timing", m_en, 0);
        chk("addr_seq", m_ad, 0);
        chk("dv_timing", m_dv, 0);
        chk("tile_last_timing", m_tl, 0);
        chk("busy_timing", m_bz, 0);
        chk("done_timing", m_dn, 0);
        chk("read_count", nrd, NTOT);
        chk("dv_count", ndv, NTOT);
        chk("tile_last_count", ntl, NT);
        chk("done_count", ndn, 1);
        if (mode == 0) chk("done_cycle", done_at, 387);
        if (mode == 1) chk("done_cycle_stall", done_at, 390);
    endtask

    initial begin
        int ndn, nbz, ndv;

        repeat (2) @(negedge clk);
        chk("rst_outs", all_outs(), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", all_outs(), 0);

        run_pass(16'h0000, 0, 1'b0);
        run_pass(16'h0000, 1, 1'b0);
        run_pass(16'hFFF0, 0, 1'b0);

        for (int i = 0; i <= 100; i++) step(i == 0, 16'h0000, 1'b0, i == 100);
        chk("abort_dv_before", 64'(data_valid), 64'd1);
        ndn = 0; nbz = 0; ndv = 0;
        for (int i = 101; i <= 500; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0);
            if (i == 101) begin
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_dv", 64'(data_valid), 64'd0);
            end
            ndn += int'(read_done === 1'b1);
            nbz += int'(busy === 1'b1);
            ndv += int'(data_valid === 1'b1);
        end
        chk("abort_no_done", ndn, 0);
        chk("abort_idle", nbz, 0);
        chk("abort_no_dv", ndv, 0);
        run_pass(16'h0000, 0, 1'b0);

        run_pass(16'h0000, 0, 1'b1);

        for (int i = 0; i <= 60; i++) step(i == 0, 16'h0100, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", all_outs(), 0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rst_held_outs", all_outs(), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ndn = 0; nbz = 0;
        for (int i = 0; i < 450; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0);
            ndn += int'(read_done === 1'b1);
            nbz += int'(busy === 1'b1);
        end
        chk("rst_no_done", ndn, 0);
        chk("rst_idle", nbz, 0);

        run_pass(16'($urandom), 2, 1'b0);
        run_pass(16'($urandom), 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
